// File: rtl/skencode_defines_pkg.sv
// Shared types and constants for the ML-DSA-87 secret-key encoder.
// Holds the FSM state enum and field/section sizing constants.
package skencode_defines_pkg;

  typedef enum logic [2:0] {
    SKENC_IDLE,
    SKENC_S1,
    SKENC_S2,
    SKENC_T0,
    SKENC_FLUSH,
    SKENC_DONE
  } skenc_state_e;

  localparam int MLDSA_Q         = 8380417;
  localparam int ETA             = 2;
  localparam int T0_OFFSET       = 4096;
  localparam int S_BITS          = 3;
  localparam int T0_BITS         = 13;
  localparam int SK_S2_WORD_BASE = 168;
  localparam int SK_T0_WORD_BASE = 360;
  localparam int SK_TOTAL_WORDS  = 1192;

endpackage

// File: rtl/skencode_coeff_map.sv
// Four-lane coefficient mapper: s1/s2 -> 3-bit, t0 -> 13-bit fields.
// Ports: rd_data (4x24b lanes), t0_mode; coeff_bits (packed), lane_err.
module skencode_coeff_map
  import skencode_defines_pkg::*;
(
  input  logic [95:0] rd_data,
  input  logic        t0_mode,
  output logic [51:0] coeff_bits,
  output logic [3:0]  lane_err
);

  localparam logic [2:0]  Q_LO3  = 3'(MLDSA_Q);
  localparam logic [12:0] Q_LO13 = 13'(MLDSA_Q);
  localparam logic [22:0] Q23    = 23'(MLDSA_Q);

  // Field values are taken mod 2^bits, so only the low
  // coefficient bits enter the subtraction.
  function automatic logic [3:0] map_s(input logic [22:0] c);
    logic [2:0] v;
    logic       e;
    e = 1'b0;
    v = 3'(ETA) - c[2:0];
    if (c > 23'(ETA)) begin
      if (c >= Q23 - 23'(ETA))
        v = 3'(ETA) + Q_LO3 - c[2:0];
      else
        e = 1'b1;
    end
    return {e, v};
  endfunction

  // Legal t0 range is -4095..4096, so q-4095 is still legal.
  function automatic logic [13:0] map_t0(input logic [22:0] c);
    logic [12:0] v;
    logic        e;
    e = 1'b0;
    v = 13'(T0_OFFSET) - c[12:0];
    if (c > 23'(T0_OFFSET)) begin
      if (c >= Q23 - 23'(T0_OFFSET - 1))
        v = 13'(T0_OFFSET) + Q_LO13 - c[12:0];
      else
        e = 1'b1;
    end
    return {e, v};
  endfunction

  always_comb begin
    coeff_bits = '0;
    lane_err   = '0;
    for (int j = 0; j < 4; j++) begin
      if (t0_mode)
        {lane_err[j], coeff_bits[13*j +: 13]} =
          map_t0(rd_data[24*j +: 23]);
      else
        {lane_err[j], coeff_bits[3*j +: 3]} =
          map_s(rd_data[24*j +: 23]);
    end
  end

  logic unused_msb;
  assign unused_msb = ^{rd_data[95], rd_data[71],
                        rd_data[47], rd_data[23]};

endmodule

// File: rtl/skencode_ctrl.sv
// Secret-key encoder: reads s1/s2/t0 coefficients, packs a 32-bit stream.
// Ports: clk/reset_n/zeroize, start+bases, mem read port, sk write port.
module skencode_ctrl
  import skencode_defines_pkg::*;
#(
  parameter int MEM_ADDR_W = 15,
  parameter int SK_ADDR_W  = 11,
  parameter int MLDSA_L    = 7,
  parameter int MLDSA_K    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  zeroize,
  input  logic                  skencode_enable,
  input  logic [MEM_ADDR_W-1:0] s1_base_addr,
  input  logic [MEM_ADDR_W-1:0] s2_base_addr,
  input  logic [MEM_ADDR_W-1:0] t0_base_addr,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [95:0]           mem_rd_data,
  output logic                  sk_wr_en,
  output logic [SK_ADDR_W-1:0]  sk_wr_addr,
  output logic [31:0]           sk_wr_data,
  output logic                  skencode_done,
  output logic                  skencode_error
);

  localparam int S1_RD = MLDSA_L * 64;
  localparam int S2_RD = MLDSA_K * 64;
  localparam int T0_RD = MLDSA_K * 64;
  localparam logic [7:0] S_CHUNK = 8'(4 * S_BITS);
  localparam logic [7:0] T_CHUNK = 8'(4 * T0_BITS);

  skenc_state_e state, state_n, sec_next;

  logic [127:0] bitbuf, bitbuf_ae, bitbuf_n;
  logic [7:0]   fill, fill_ae, fill_n;
  logic [7:0]   ret_bits, infl_bits, new_bits;
  logic [9:0]   rd_cnt, rd_cnt_n, sec_last;
  logic [SK_ADDR_W-1:0]  wr_cnt;
  logic [MEM_ADDR_W-1:0] s1_base, s2_base, t0_base;
  logic [MEM_ADDR_W-1:0] sec_base, issue_addr;
  logic rd_t0, ret_valid, ret_t0;
  logic issue, issue_t0, start, emit, room;
  logic [51:0] coeff_bits;
  logic [3:0]  lane_err;

  skencode_coeff_map u_map (
    .rd_data    (mem_rd_data),
    .t0_mode    (ret_t0),
    .coeff_bits (coeff_bits),
    .lane_err   (lane_err)
  );

  // Emit first, then append the returning chunk above what is left.
  always_comb begin
    emit      = fill >= 8'd32;
    fill_ae   = emit ? fill - 8'd32 : fill;
    bitbuf_ae = emit ? {32'b0, bitbuf[127:32]} : bitbuf;
    ret_bits  = ret_valid ? (ret_t0 ? T_CHUNK : S_CHUNK) : 8'd0;
    infl_bits = mem_rd_en ? (rd_t0 ? T_CHUNK : S_CHUNK) : 8'd0;
    fill_n    = fill_ae + ret_bits;
    bitbuf_n  = bitbuf_ae;
    if (ret_valid)
      bitbuf_n = bitbuf_ae | ({76'b0, coeff_bits} << fill_ae);
    issue_t0  = state == SKENC_T0;
    new_bits  = issue_t0 ? T_CHUNK : S_CHUNK;
    room = ({1'b0, fill_n} + {1'b0, infl_bits}
           + {1'b0, new_bits}) <= 9'd128;
  end

  always_comb begin
    sec_base = s1_base;
    sec_last = 10'(S1_RD - 1);
    sec_next = SKENC_S2;
    unique case (1'b1)
      (state == SKENC_S2): begin
        sec_base = s2_base;
        sec_last = 10'(S2_RD - 1);
        sec_next = SKENC_T0;
      end
      (state == SKENC_T0): begin
        sec_base = t0_base;
        sec_last = 10'(T0_RD - 1);
        sec_next = SKENC_FLUSH;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    issue      = 1'b0;
    issue_addr = mem_rd_addr;
    rd_cnt_n   = rd_cnt;
    start      = 1'b0;
    unique case (state)
      SKENC_IDLE: begin
        if (skencode_enable) begin
          start      = 1'b1;
          issue      = 1'b1;
          issue_addr = s1_base_addr;
          rd_cnt_n   = 10'd1;
          state_n    = SKENC_S1;
        end
      end
      SKENC_S1, SKENC_S2, SKENC_T0: begin
        if (room) begin
          issue      = 1'b1;
          issue_addr = sec_base + MEM_ADDR_W'(rd_cnt);
          rd_cnt_n   = rd_cnt + 10'd1;
          if (rd_cnt == sec_last) begin
            rd_cnt_n = '0;
            state_n  = sec_next;
          end
        end
      end
      SKENC_FLUSH: begin
        if (fill == 8'd0 && !mem_rd_en && !ret_valid
            && wr_cnt == SK_ADDR_W'(SK_TOTAL_WORDS))
          state_n = SKENC_DONE;
      end
      SKENC_DONE: state_n = SKENC_IDLE;
      default:    state_n = SKENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state <= SKENC_IDLE;
    else if (zeroize) state <= SKENC_IDLE;
    else              state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || zeroize) begin
      bitbuf <= '0;  fill <= '0;  rd_cnt <= '0;
      wr_cnt <= '0;  rd_t0 <= 1'b0;
      ret_valid <= 1'b0;  ret_t0 <= 1'b0;
      s1_base <= '0;  s2_base <= '0;  t0_base <= '0;
      mem_rd_en <= 1'b0;  mem_rd_addr <= '0;
      sk_wr_en <= 1'b0;  sk_wr_addr <= '0;
      sk_wr_data <= '0;  skencode_done <= 1'b0;
      skencode_error <= 1'b0;
    end else begin
      mem_rd_en <= issue;
      rd_t0     <= issue_t0;
      if (issue) mem_rd_addr <= issue_addr;
      ret_valid <= mem_rd_en;
      ret_t0    <= rd_t0;
      rd_cnt    <= rd_cnt_n;
      fill      <= fill_n;
      bitbuf    <= bitbuf_n;
      sk_wr_en  <= emit;
      if (emit) begin
        sk_wr_data <= bitbuf[31:0];
        sk_wr_addr <= wr_cnt;
        wr_cnt     <= wr_cnt + 1'b1;
      end
      skencode_done <= state_n == SKENC_DONE;
      if (start) begin
        s1_base <= s1_base_addr;
        s2_base <= s2_base_addr;
        t0_base <= t0_base_addr;
        wr_cnt  <= '0;
        skencode_error <= 1'b0;
      end else if (ret_valid && |lane_err) begin
        skencode_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_skencode_ctrl.sv
// Scoreboard bench for skencode_ctrl against a bit-stream packing model.
// Drives memory/start; a negedge monitor checks every key word written.
module tb_skencode_ctrl;
  import skencode_defines_pkg::*;

  localparam int AW    = 15;
  localparam int SW    = 11;
  localparam int NCOEF = 5888;
  localparam int S2_K  = 1792;
  localparam int T0_K  = 3840;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic zeroize = 1'b0;
  logic skencode_enable = 1'b0;
  logic [AW-1:0] s1_base_addr = '0;
  logic [AW-1:0] s2_base_addr = '0;
  logic [AW-1:0] t0_base_addr = '0;
  logic mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [95:0] mem_rd_data = '0;
  logic sk_wr_en;
  logic [SW-1:0] sk_wr_addr;
  logic [31:0] sk_wr_data;
  logic skencode_done, skencode_error;

  skencode_ctrl dut (
    .clk(clk), .reset_n(reset_n), .zeroize(zeroize),
    .skencode_enable(skencode_enable),
    .s1_base_addr(s1_base_addr), .s2_base_addr(s2_base_addr),
    .t0_base_addr(t0_base_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .sk_wr_en(sk_wr_en), .sk_wr_addr(sk_wr_addr),
    .sk_wr_data(sk_wr_data),
    .skencode_done(skencode_done), .skencode_error(skencode_error)
  );

  always #5 clk = ~clk;

  logic [95:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int unsigned coef [NCOEF];
  logic [42:0] exp_q [$];
  logic [42:0] e_word;
  logic [31:0] got [SK_TOTAL_WORDS];
  int checks = 0, errors = 0;
  int done_cnt = 0, wr_seen = 0, wr_base = 0, done_base = 0;
  logic prev_wr = 1'b0;
  logic [SW-1:0] last_addr = '0;
  bit exp_err;

  always @(negedge clk) begin
    if (reset_n && sk_wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_write: got addr %0d data %h, expected none",
                 sk_wr_addr, sk_wr_data);
      end else begin
        e_word = exp_q.pop_front();
        if ({sk_wr_addr, sk_wr_data} !== e_word) begin
          errors++;
          $display("FAIL word: got addr %0d data %h, expected addr %0d data %h",
                   sk_wr_addr, sk_wr_data, e_word[42:32], e_word[31:0]);
        end
      end
      if (sk_wr_addr < SW'(SK_TOTAL_WORDS)) got[sk_wr_addr] = sk_wr_data;
      last_addr = sk_wr_addr;
      wr_seen++;
    end
    if (reset_n && skencode_done) begin
      checks++;
      done_cnt++;
      if (!prev_wr || last_addr != SW'(SK_TOTAL_WORDS - 1)) begin
        errors++;
        $display("FAIL done_timing: prev write %0b addr %0d, expected 1 addr %0d",
                 prev_wr, last_addr, SK_TOTAL_WORDS - 1);
      end
    end
    prev_wr = reset_n && sk_wr_en;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_rd_en"},   32'(mem_rd_en), 0);
    chk({name, "_rd_addr"}, 32'(mem_rd_addr), 0);
    chk({name, "_wr_en"},   32'(sk_wr_en), 0);
    chk({name, "_wr_addr"}, 32'(sk_wr_addr), 0);
    chk({name, "_wr_data"}, sk_wr_data, 0);
    chk({name, "_done"},    32'(skencode_done), 0);
    chk({name, "_error"},   32'(skencode_error), 0);
  endtask

  function automatic int unsigned to_mem(input int x);
    return (x < 0) ? int'(MLDSA_Q + x) : x;
  endfunction

  task automatic fill_zero();
    for (int k = 0; k < NCOEF; k++) coef[k] = 0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NCOEF; k++) begin
      if (k < T0_K) coef[k] = to_mem(int'($urandom_range(4)) - ETA);
      else coef[k] = to_mem(int'($urandom_range(8191)) - 4095);
    end
    s1_base_addr = AW'($urandom_range(3000));
    s2_base_addr = AW'($urandom_range(8000, 4000));
    t0_base_addr = AW'($urandom_range(30000, 9000));
  endtask

  // Signed centred value, field = offset - x, bits appended LSB first.
  task automatic build_expected(output bit err);
    bit bq[$];
    int x, v, nb, off;
    logic [31:0] w;
    err = 0;
    exp_q.delete();
    for (int k = 0; k < NCOEF; k++) begin
      x = (coef[k] > MLDSA_Q / 2) ? int'(coef[k]) - MLDSA_Q : int'(coef[k]);
      nb  = (k >= T0_K) ? T0_BITS : S_BITS;
      off = (k >= T0_K) ? T0_OFFSET : ETA;
      if (k >= T0_K) begin
        if (x < -4095 || x > 4096) err = 1;
      end else if (x < -ETA || x > ETA) err = 1;
      v = off - x;
      for (int b = 0; b < nb; b++) bq.push_back(v[b]);
    end
    for (int i = 0; i < SK_TOTAL_WORDS; i++) begin
      for (int b = 0; b < 32; b++) w[b] = bq[32*i + b];
      exp_q.push_back({SW'(i), w});
    end
  endtask

  task automatic load_mem();
    logic [95:0] w;
    logic [AW-1:0] a;
    for (int r = 0; r < NCOEF / 4; r++) begin
      for (int j = 0; j < 4; j++) w[24*j +: 24] = 24'(coef[4*r + j]);
      if (r < 448) a = s1_base_addr + AW'(r);
      else if (r < 960) a = s2_base_addr + AW'(r - 448);
      else a = t0_base_addr + AW'(r - 960);
      mem[a] = w;
    end
  endtask

  task automatic start_run(input string name);
    build_expected(exp_err);
    load_mem();
    wr_base = wr_seen;
    done_base = done_cnt;
    @(negedge clk); skencode_enable = 1'b1;
    @(negedge clk); skencode_enable = 1'b0;
    chk({name, "_err_clear"}, 32'(skencode_error), 0);
    chk({name, "_first_rd"}, 32'(mem_rd_en), 1);
    chk({name, "_first_addr"}, 32'(mem_rd_addr), 32'(s1_base_addr));
  endtask

  task automatic finish_run(input string name);
    for (int i = 0; i < 20000 && done_cnt == done_base; i++)
      @(negedge clk);
    chk({name, "_done_count"}, 32'(done_cnt - done_base), 1);
    chk({name, "_writes"}, 32'(wr_seen - wr_base), SK_TOTAL_WORDS);
    chk({name, "_missing"}, 32'(exp_q.size()), 0);
    chk({name, "_error"}, 32'(skencode_error), 32'(exp_err));
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(skencode_done), 0);
  endtask

  task automatic wait_writes(input string name, input int n);
    for (int i = 0; i < 5000 && wr_seen - wr_base < n; i++)
      @(negedge clk);
    chk({name, "_reached"}, 32'(wr_seen - wr_base >= n), 1);
  endtask

  task automatic quiet_window(input string name);
    int d0, w0;
    d0 = done_cnt;
    w0 = wr_seen;
    repeat (1500) @(negedge clk);
    chk({name, "_no_done"}, 32'(done_cnt - d0), 0);
    chk({name, "_no_write"}, 32'(wr_seen - w0), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    fill_zero();
    s1_base_addr = 15'd100; s2_base_addr = 15'd5000;
    t0_base_addr = 15'd12000;
    start_run("zero");
    finish_run("zero");
    chk("zero_w0", got[0], 32'h92492492);
    chk("zero_w1", got[1], 32'h24924924);
    chk("zero_w2", got[2], 32'h49249249);
    chk("zero_w360", got[SK_T0_WORD_BASE], 32'h02001000);
    chk("zero_w168", got[SK_S2_WORD_BASE], 32'h92492492);

    fill_zero();
    coef[0] = MLDSA_Q - 2; coef[1] = MLDSA_Q - 1;
    coef[2] = 1;           coef[3] = 2;
    coef[T0_K] = MLDSA_Q - 4095;
    coef[T0_K + 1] = 4096;
    start_run("edge");
    finish_run("edge");
    chk("edge_s_lane0", 32'(got[0][2:0]), 4);
    chk("edge_s_lane1", 32'(got[0][5:3]), 3);
    chk("edge_s_lane2", 32'(got[0][8:6]), 1);
    chk("edge_s_lane3", 32'(got[0][11:9]), 0);
    chk("edge_t0_min", 32'(got[SK_T0_WORD_BASE][12:0]), 8191);
    chk("edge_t0_max", 32'(got[SK_T0_WORD_BASE][25:13]), 0);

    fill_zero();
    coef[S2_K] = 3;
    coef[T0_K + 7] = 5000;
    start_run("bad");
    wait_writes("bad_mid", 400);
    chk("bad_err_mid", 32'(skencode_error), 1);
    finish_run("bad");
    chk("bad_err_sticky", 32'(skencode_error), 1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      start_run($sformatf("rand%0d", r));
      finish_run($sformatf("rand%0d", r));
    end

    fill_random();
    start_run("zrun");
    wait_writes("zrun_t0", 400);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check_idle("zeroize");
    exp_q.delete();
    quiet_window("zeroize");

    fill_random();
    start_run("rrun");
    wait_writes("rrun_s2", 200);
    #2 reset_n = 1'b0;
    #1 check_idle("async_reset");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    quiet_window("reset");

    fill_random();
    start_run("fresh");
    finish_run("fresh");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
